// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 merge and its matching 1:2 demux.
// Both sides use the same channel-id encoding.
package mux_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. This is pure logic; the caller holds the `last` pointer.
// On contention the winner is the channel that was not served last.
module rr_arb2
  import mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       advance,
  output logic       grant,
  output logic       any
);

  always_comb begin
    grant = CH0;
    if (req[0] && req[1]) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = CH1;
    end
  end

  // A grant is real only when the output register can take the beat.
  assign any = advance & (|req);

endmodule

// File: rtl/mux2x1_rr.sv
// Registered 2:1 round-robin merge with valid/ready on every port.
// out_sel tags each beat with its source so a downstream demux can route it back.
module mux2x1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t state;
  logic   last;
  logic   grant;
  logic   acc;
  logic   take;
  logic   space;
  logic   advance;

  assign out_valid = (state == FULL);
  assign take      = out_valid & out_ready;
  assign space     = ~out_valid | out_ready;
  // The rst term keeps both readies low while reset is held.
  assign advance   = en & space & ~rst;

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .last    (last),
    .advance (advance),
    .grant   (grant),
    .any     (acc)
  );

  assign in0_ready = advance & (grant == CH0);
  assign in1_ready = advance & (grant == CH1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= CH0;
      last     <= CH1;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      if (acc) begin
        state    <= FULL;
        out_data <= (grant == CH1) ? in1_data : in0_data;
        out_sel  <= grant;
        last     <= grant;
        if (grant == CH1) begin
          cnt1 <= cnt1 + CNT_W'(1);
        end else begin
          cnt0 <= cnt0 + CNT_W'(1);
        end
      end else if (take) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mux2x1_rr.sv
// Directed bench for mux2x1_rr: main instance plus a 4-bit-counter instance for wrap.
`timescale 1ns/1ps
module tb_mux2x1_rr;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data;
  logic [15:0] cnt0, cnt1;

  logic       w_in0_valid, w_in1_valid;
  logic [7:0] w_in0_data, w_in1_data;
  logic       w_in0_ready, w_in1_ready, w_out_valid, w_out_sel;
  logic [7:0] w_out_data;
  logic [3:0] w_cnt0, w_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux2x1_rr #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .cnt0(cnt0), .cnt1(cnt1)
  );

  mux2x1_rr #(.WIDTH(8), .CNT_W(4)) dutw (
    .clk(clk), .rst(rst), .en(1'b1),
    .in0_valid(w_in0_valid), .in0_ready(w_in0_ready), .in0_data(w_in0_data),
    .in1_valid(w_in1_valid), .in1_ready(w_in1_ready), .in1_data(w_in1_data),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_sel(w_out_sel), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d0, d1;
    logic       exp_sel;

    rst = 1'b1; en = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = 8'h00; in1_data = 8'h00;
    w_in0_valid = 1'b0; w_in1_valid = 1'b0; w_in0_data = 8'h00; w_in1_data = 8'h00;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single channel beat
    in0_valid = 1'b1; in0_data = 8'hA5; out_ready = 1'b1;
    #1;
    chk("single_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("single_in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    in0_valid = 1'b0;
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_out_data", {24'd0, out_data}, 32'hA5);
    chk("single_out_sel", {31'd0, out_sel}, 32'd0);
    chk("single_cnt0", {16'd0, cnt0}, 32'd1);
    tick();
    chk("single_drained", {31'd0, out_valid}, 32'd0);

    // Reset pulse between edges so the pointer starts at ch0 again
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("pulse_cnt0", {16'd0, cnt0}, 32'd0);

    // Contention: strict alternation starting with ch0
    d0 = 8'h10; d1 = 8'h20;
    in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel = i[0];
      in0_data = d0; in1_data = d1;
      #1;
      chk("cont_in0_ready", {31'd0, in0_ready}, {31'd0, ~exp_sel});
      chk("cont_in1_ready", {31'd0, in1_ready}, {31'd0, exp_sel});
      tick();
      chk("cont_out_valid", {31'd0, out_valid}, 32'd1);
      chk("cont_out_sel", {31'd0, out_sel}, {31'd0, exp_sel});
      chk("cont_out_data", {24'd0, out_data}, {24'd0, exp_sel ? d1 : d0});
      if (exp_sel) d1 = d1 + 8'd1; else d0 = d0 + 8'd1;
    end
    in0_data = d0; in1_data = d1;
    chk("cont_cnt0", {16'd0, cnt0}, 32'd3);
    chk("cont_cnt1", {16'd0, cnt1}, 32'd3);

    // Backpressure: register holds 0x22 from ch1
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in0_ready", {31'd0, in0_ready}, 32'd0);
      chk("bp_in1_ready", {31'd0, in1_ready}, 32'd0);
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", {24'd0, out_data}, 32'h22);
      chk("bp_out_sel", {31'd0, out_sel}, 32'd1);
      chk("bp_cnt0", {16'd0, cnt0}, 32'd3);
      chk("bp_cnt1", {16'd0, cnt1}, 32'd3);
    end

    // Release: drain and accept in the same cycle
    out_ready = 1'b1;
    #1;
    chk("rel_in0_ready", {31'd0, in0_ready}, 32'd1);
    tick();
    chk("rel_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rel_out_data", {24'd0, out_data}, 32'h13);
    chk("rel_out_sel", {31'd0, out_sel}, 32'd0);
    chk("rel_cnt0", {16'd0, cnt0}, 32'd4);
    in0_data = 8'h14;

    // Enable gating: hold FULL, then drain with no accepts
    en = 1'b0; out_ready = 1'b0;
    #1;
    chk("en_in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("en_in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    chk("en_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("en_hold_data", {24'd0, out_data}, 32'h13);
    out_ready = 1'b1;
    #1;
    chk("en_drain_ready", {31'd0, in0_ready | in1_ready}, 32'd0);
    tick();
    chk("en_drained", {31'd0, out_valid}, 32'd0);
    chk("en_cnt0", {16'd0, cnt0}, 32'd4);
    chk("en_cnt1", {16'd0, cnt1}, 32'd3);

    // Raise enable: ch0 was served last, so ch1 wins
    en = 1'b1;
    #1;
    chk("en_up_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("en_up_in0_ready", {31'd0, in0_ready}, 32'd0);
    tick();
    chk("en_up_out_sel", {31'd0, out_sel}, 32'd1);
    chk("en_up_out_data", {24'd0, out_data}, 32'h23);
    chk("en_up_cnt1", {16'd0, cnt1}, 32'd4);
    in1_data = 8'h24;
    tick();
    chk("burst_out_sel", {31'd0, out_sel}, 32'd0);
    chk("burst_out_data", {24'd0, out_data}, 32'h14);

    // Asynchronous reset mid-burst, between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("arst_cnt1", {16'd0, cnt1}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_readies", {31'd0, in0_ready | in1_ready}, 32'd0);
    rst = 1'b0;
    in0_data = 8'h15;
    #1;
    chk("arst_in0_ready", {31'd0, in0_ready}, 32'd1);
    tick();
    chk("arst_first_sel", {31'd0, out_sel}, 32'd0);
    chk("arst_first_data", {24'd0, out_data}, 32'h15);
    chk("arst_first_cnt0", {16'd0, cnt0}, 32'd1);
    in0_valid = 1'b0; in1_valid = 1'b0;

    // Counter wrap on the 4-bit instance: 17 accepts on ch1
    w_in1_data = 8'h77;
    w_in1_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    w_in1_valid = 1'b0;
    chk("wrap_cnt1", {28'd0, w_cnt1}, 32'd1);
    chk("wrap_cnt0", {28'd0, w_cnt0}, 32'd0);
    chk("wrap_out_sel", {31'd0, w_out_sel}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
